// File: rtl/decoder_n2pow_seq.sv
// Registered N-to-2^N one-hot decoder with a valid/ready command input.
// Output modes are HOLD, PULSE, SCAN and CLEAR; ACTIVE_LOW inverts only y.
module decoder_n2pow_seq #(
  parameter int N = 2,
  parameter bit ACTIVE_LOW = 1'b0,
  localparam int OUT_W = 2**N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_code,
  input  logic [1:0]       in_mode,
  input  logic [N-1:0]     in_len,
  output logic [OUT_W-1:0] y,
  output logic             y_valid,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_PULSE,
    S_SCAN
  } state_e;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_PULSE = 2'b01;
  localparam logic [1:0] M_SCAN  = 2'b10;
  localparam logic [1:0] M_CLEAR = 2'b11;

  state_e     state_q, state_d;
  logic [N-1:0] code_q, code_d;
  logic [N-1:0] len_q, len_d;
  logic [N-1:0] step_q, step_d;

  logic         accept;
  logic         last;
  logic [N-1:0] idx;
  logic [OUT_W-1:0] y_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      len_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      len_q   <= len_d;
      step_q  <= step_d;
    end
  end

  assign in_ready = (state_q != S_SCAN);
  assign accept   = in_valid && in_ready;
  assign last     = (step_q == len_q);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    len_d   = len_q;
    step_d  = step_q;
    unique case (state_q)
      S_SCAN: begin
        if (last) begin
          state_d = S_IDLE;
          step_d  = '0;
        end else begin
          step_d = step_q + N'(1);
        end
      end
      S_PULSE: state_d = S_IDLE;
      default: ;
    endcase
    // An accept is only possible outside SCAN, so it overrides the above.
    if (accept) begin
      code_d = in_code;
      len_d  = in_len;
      step_d = '0;
      unique case (in_mode)
        M_HOLD:  state_d = S_HOLD;
        M_PULSE: state_d = S_PULSE;
        M_SCAN:  state_d = S_SCAN;
        M_CLEAR: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // step_q is zero in HOLD/PULSE, so one adder serves every mode.
  assign idx = code_q + step_q;

  always_comb begin
    y_raw = '0;
    if (state_q != S_IDLE) y_raw[idx] = 1'b1;
  end

  assign y       = ACTIVE_LOW ? ~y_raw : y_raw;
  assign y_valid = (state_q != S_IDLE);
  assign done    = (state_q == S_SCAN) && last;

endmodule

// File: tb/tb_decoder_n2pow_seq.sv
// Directed bench for decoder_n2pow_seq: a vector table for N=2 plus
// hand sequences for async reset and an ACTIVE_LOW N=3 instance.
module tb_decoder_n2pow_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       v, rdy, yv, dn;
  logic [1:0] m, c, l;
  logic [3:0] y;

  logic       av, ardy, ayv, adn;
  logic [1:0] am;
  logic [2:0] ac, al;
  logic [7:0] ay;

  int errors = 0;
  int checks = 0;

  decoder_n2pow_seq #(.N(2), .ACTIVE_LOW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v), .in_ready(rdy),
    .in_code(c), .in_mode(m), .in_len(l),
    .y(y), .y_valid(yv), .done(dn)
  );

  decoder_n2pow_seq #(.N(3), .ACTIVE_LOW(1'b1)) u_al (
    .clk(clk), .rst_n(rst_n),
    .in_valid(av), .in_ready(ardy),
    .in_code(ac), .in_mode(am), .in_len(al),
    .y(ay), .y_valid(ayv), .done(adn)
  );

  typedef struct {
    logic       v;
    logic [1:0] m;
    logic [1:0] c;
    logic [1:0] l;
    logic [3:0] y;
    logic       yv;
    logic       d;
    logic       r;
  } vec_t;

  localparam int NV = 19;
  vec_t vt[NV];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk4(input string nm, input logic [3:0] ey,
                      input logic eyv, input logic ed, input logic er);
    chk({nm, ".y"}, int'(y), int'(ey));
    chk({nm, ".y_valid"}, int'(yv), int'(eyv));
    chk({nm, ".done"}, int'(dn), int'(ed));
    chk({nm, ".in_ready"}, int'(rdy), int'(er));
  endtask

  task automatic drive(input logic iv, input logic [1:0] im,
                       input logic [1:0] ic, input logic [1:0] il);
    v = iv; m = im; c = ic; l = il;
  endtask

  initial begin
    // HOLD sweep, ignored input change, CLEAR
    vt[0]  = '{1, 2'b00, 2'd0, 2'd0, 4'b0001, 1, 0, 1};
    vt[1]  = '{1, 2'b00, 2'd1, 2'd0, 4'b0010, 1, 0, 1};
    vt[2]  = '{1, 2'b00, 2'd2, 2'd0, 4'b0100, 1, 0, 1};
    vt[3]  = '{1, 2'b00, 2'd3, 2'd0, 4'b1000, 1, 0, 1};
    vt[4]  = '{0, 2'b01, 2'd0, 2'd2, 4'b1000, 1, 0, 1};
    vt[5]  = '{1, 2'b11, 2'd1, 2'd0, 4'b0000, 0, 0, 1};
    // PULSE single, then back-to-back
    vt[6]  = '{1, 2'b01, 2'd2, 2'd0, 4'b0100, 1, 0, 1};
    vt[7]  = '{0, 2'b01, 2'd2, 2'd0, 4'b0000, 0, 0, 1};
    vt[8]  = '{1, 2'b01, 2'd1, 2'd0, 4'b0010, 1, 0, 1};
    vt[9]  = '{1, 2'b01, 2'd3, 2'd0, 4'b1000, 1, 0, 1};
    vt[10] = '{0, 2'b00, 2'd0, 2'd0, 4'b0000, 0, 0, 1};
    // SCAN with wrap; in_valid held high is ignored
    vt[11] = '{1, 2'b10, 2'd2, 2'd3, 4'b0100, 1, 0, 0};
    vt[12] = '{1, 2'b00, 2'd0, 2'd0, 4'b1000, 1, 0, 0};
    vt[13] = '{1, 2'b00, 2'd0, 2'd0, 4'b0001, 1, 0, 0};
    vt[14] = '{1, 2'b00, 2'd0, 2'd0, 4'b0010, 1, 1, 0};
    vt[15] = '{1, 2'b00, 2'd0, 2'd0, 4'b0000, 0, 0, 1};
    vt[16] = '{0, 2'b00, 2'd0, 2'd0, 4'b0000, 0, 0, 1};
    // SCAN len=0
    vt[17] = '{1, 2'b10, 2'd1, 2'd0, 4'b0010, 1, 1, 0};
    vt[18] = '{0, 2'b00, 2'd0, 2'd0, 4'b0000, 0, 0, 1};

    drive(0, 2'b00, 2'd0, 2'd0);
    av = 0; am = 2'b00; ac = 3'd0; al = 3'd0;

    #1;
    chk4("reset", 4'b0000, 0, 0, 1);
    chk("al.reset.y", int'(ay), 32'hFF);
    chk("al.reset.y_valid", int'(ayv), 0);
    #11 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].v, vt[i].m, vt[i].c, vt[i].l);
      @(posedge clk); #1;
      chk4($sformatf("vec%0d", i), vt[i].y, vt[i].yv, vt[i].d, vt[i].r);
    end

    // async reset mid-cycle while holding
    drive(1, 2'b00, 2'd2, 2'd0);
    @(posedge clk); #1;
    chk4("pre_rst", 4'b0100, 1, 0, 1);
    drive(0, 2'b00, 2'd0, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    chk4("async_rst", 4'b0000, 0, 0, 1);
    @(negedge clk) rst_n = 1'b1;

    // reset mid-SCAN
    drive(1, 2'b10, 2'd0, 2'd3);
    @(posedge clk); #1;
    chk4("scan_s0", 4'b0001, 1, 0, 0);
    drive(0, 2'b00, 2'd0, 2'd0);
    @(posedge clk); #1;
    chk4("scan_s1", 4'b0010, 1, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk4("scan_abort", 4'b0000, 0, 0, 1);
    @(posedge clk); #1;
    chk4("scan_abort_edge", 4'b0000, 0, 0, 1);
    @(negedge clk) rst_n = 1'b1;
    drive(1, 2'b00, 2'd1, 2'd0);
    @(posedge clk); #1;
    chk4("post_rst_hold", 4'b0010, 1, 0, 1);
    drive(0, 2'b00, 2'd0, 2'd0);

    // ACTIVE_LOW, N=3 instance
    av = 1; am = 2'b00; ac = 3'd5; al = 3'd0;
    @(posedge clk); #1;
    chk("al.hold.y", int'(ay), 32'hDF);
    chk("al.hold.y_valid", int'(ayv), 1);
    av = 1; am = 2'b10; ac = 3'd7; al = 3'd0;
    @(posedge clk); #1;
    chk("al.scan.y", int'(ay), 32'h7F);
    chk("al.scan.done", int'(adn), 1);
    chk("al.scan.in_ready", int'(ardy), 0);
    av = 0;
    @(posedge clk); #1;
    chk("al.idle.y", int'(ay), 32'hFF);
    chk("al.idle.y_valid", int'(ayv), 0);
    chk("al.idle.done", int'(adn), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
